// File: rtl/dcf77_bit_decoder.sv
// DCF77 time-code bit decoder: classifies synchronized pulse widths and gaps
// into bits, tracks minute-marker sync and reports each complete 59-bit frame.
module dcf77_bit_decoder #(
  parameter int CLOCK_FREQUENCY = 16000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dcf_in,
  output logic [58:0] dcf_bits,
  output logic        frame_valid,
  output logic [5:0]  bit_count,
  output logic        synced,
  output logic        frame_error,
  output logic        signal_lost
);

  localparam int DIV = CLOCK_FREQUENCY / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {UNSYNC, GAP, PULSE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [2:0]    sync_q;
  logic          rise, fall, edge_any;
  logic [11:0]   ms_cnt;
  logic [58:0]   shift_q, shift_n, bits_n;
  logic [5:0]    count_n;
  logic          synced_n, valid_n, error_n, lost_n;

  assign tick = (pre_cnt == PW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, as real flops do.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else sync_q <= {sync_q[1:0], dcf_in};
  end

  // sync_q[1] is the second synchronizer stage; sync_q[2] only delays it for edges.
  assign rise     = sync_q[1] & ~sync_q[2];
  assign fall     = ~sync_q[1] & sync_q[2];
  assign edge_any = rise | fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ms_cnt <= '0;
    else if (edge_any) ms_cnt <= '0;
    else if (tick && ms_cnt != 12'd4095) ms_cnt <= ms_cnt + 12'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= UNSYNC;
      shift_q     <= '0;
      dcf_bits    <= '0;
      bit_count   <= '0;
      synced      <= 1'b0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      state       <= state_n;
      shift_q     <= shift_n;
      dcf_bits    <= bits_n;
      bit_count   <= count_n;
      synced      <= synced_n;
      frame_valid <= valid_n;
      frame_error <= error_n;
      signal_lost <= lost_n;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    shift_n  = shift_q;
    bits_n   = dcf_bits;
    count_n  = bit_count;
    synced_n = synced;
    valid_n  = 1'b0;
    error_n  = 1'b0;
    lost_n   = signal_lost;
    if (edge_any) lost_n = 1'b0;

    case (state)
      UNSYNC: begin
        if (rise && ms_cnt >= 12'd1500) begin
          state_n  = PULSE;
          synced_n = 1'b1;
          count_n  = '0;
        end
      end
      PULSE: begin
        if (fall) begin
          if (ms_cnt >= 12'd40 && ms_cnt <= 12'd260) begin
            shift_n = {(ms_cnt >= 12'd141), shift_q[58:1]};
            if (bit_count != 6'd59) count_n = bit_count + 6'd1;
            state_n = GAP;
          end else begin
            error_n = 1'b1;
            state_n = UNSYNC;
          end
        end
      end
      GAP: begin
        if (rise) begin
          if (ms_cnt >= 12'd700 && ms_cnt <= 12'd1000) begin
            if (bit_count == 6'd59) begin
              error_n = 1'b1;
              state_n = UNSYNC;
            end else begin
              state_n = PULSE;
            end
          end else if (ms_cnt >= 12'd1500 && ms_cnt <= 12'd2000) begin
            if (bit_count == 6'd59) begin
              bits_n  = shift_q;
              valid_n = 1'b1;
            end else begin
              error_n = 1'b1;
            end
            count_n = '0;
            state_n = PULSE;
          end else begin
            error_n = 1'b1;
            state_n = UNSYNC;
          end
        end
      end
      default: state_n = UNSYNC;
    endcase

    // Carrier silence overrides everything; a concurrent edge restarts the count.
    if (!edge_any && ms_cnt >= 12'd3000) begin
      state_n = UNSYNC;
      lost_n  = 1'b1;
    end

    if (state_n == UNSYNC) begin
      synced_n = 1'b0;
      count_n  = '0;
    end
  end

endmodule

// File: tb/tb_dcf77_bit_decoder.sv
// Bench for dcf77_bit_decoder at 1 clk per ms; frames go through a scoreboard
// queue that the frame_valid monitor drains.
module tb_dcf77_bit_decoder;

  localparam int CF = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        dcf_in;
  logic [58:0] dcf_bits;
  logic        frame_valid;
  logic [5:0]  bit_count;
  logic        synced;
  logic        frame_error;
  logic        signal_lost;

  int vectors = 0;
  int miscompares = 0;
  int fe_cnt = 0;
  int fv_cnt = 0;
  logic [58:0] exp_q[$];
  logic [58:0] model_sr = '0;
  logic [58:0] last_frame = '0;
  logic [58:0] mon_exp;
  logic [58:0] golden;

  dcf77_bit_decoder #(.CLOCK_FREQUENCY(CF)) dut (
    .clk(clk), .reset(reset), .dcf_in(dcf_in), .dcf_bits(dcf_bits),
    .frame_valid(frame_valid), .bit_count(bit_count), .synced(synced),
    .frame_error(frame_error), .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_error) fe_cnt++;
    if (frame_valid && frame_error) begin
      miscompares++;
      $display("FAIL valid_error_overlap frame_valid=1 frame_error=1, required not both");
    end
    if (frame_valid) begin
      fv_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_frame dcf_bits=%h, required no frame_valid", dcf_bits);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dcf_bits !== mon_exp) begin
          miscompares++;
          $display("FAIL frame_bits got %h required %h", dcf_bits, mon_exp);
        end
        last_frame = mon_exp;
      end
    end
  end

  task automatic hold(input logic level, input int ms);
    dcf_in = level;
    repeat (ms) @(negedge clk);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    model_sr = {b, model_sr[58:1]};
    hold(1'b1, b ? 150 : 50);
    hold(1'b0, 705);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    dcf_in = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({dcf_bits, frame_valid, bit_count, synced, frame_error, signal_lost} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs bits=%h fv=%b cnt=%0d sy=%b fe=%b sl=%b, required all 0",
               dcf_bits, frame_valid, bit_count, synced, frame_error, signal_lost);
    end
    reset = 1'b1;
  endtask

  task automatic test_signal_loss_from_reset();
    hold(1'b0, 2990);
    vectors++;
    if (signal_lost !== 1'b0) begin
      miscompares++;
      $display("FAIL loss_early signal_lost=%b required 0", signal_lost);
    end
    hold(1'b0, 20);
    vectors++;
    if (signal_lost !== 1'b1 || synced !== 1'b0) begin
      miscompares++;
      $display("FAIL loss_set signal_lost=%b synced=%b required 1 0", signal_lost, synced);
    end
    dcf_in = 1'b1;
    settle();
    vectors++;
    if (signal_lost !== 1'b0 || synced !== 1'b1 || bit_count !== 6'd0) begin
      miscompares++;
      $display("FAIL loss_clear signal_lost=%b synced=%b cnt=%0d required 0 1 0",
               signal_lost, synced, bit_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    hold(1'b1, 46);
    hold(1'b0, 705);
    for (int i = 1; i < 8; i++) send_bit(i[0]);
    vectors++;
    if (bit_count !== 6'd8) begin
      miscompares++;
      $display("FAIL partial_count got %0d required 8", bit_count);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({dcf_bits, frame_valid, bit_count, synced, frame_error, signal_lost} !== '0) begin
      miscompares++;
      $display("FAIL midframe_reset bits=%h cnt=%0d sy=%b, required all 0", dcf_bits, bit_count, synced);
    end
    reset = 1'b1;
    hold(1'b0, 800);
    hold(1'b1, 50);
    vectors++;
    if (synced !== 1'b0) begin
      miscompares++;
      $display("FAIL short_marker_sync synced=%b required 0", synced);
    end
  endtask

  task automatic test_full_frame();
    hold(1'b0, 1600);
    model_sr = '0;
    for (int n = 0; n < 59; n++) begin
      send_bit(n[0]);
      if (n == 0) begin
        vectors++;
        if (synced !== 1'b1 || bit_count !== 6'd1) begin
          miscompares++;
          $display("FAIL frame_sync synced=%b cnt=%0d required 1 1", synced, bit_count);
        end
      end
    end
    hold(1'b0, 895);
    vectors++;
    if (bit_count !== 6'd59) begin
      miscompares++;
      $display("FAIL count_59 got %0d required 59", bit_count);
    end
    exp_q.push_back(model_sr);
    dcf_in = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early frame_valid=%b required 0 two cycles after edge", frame_valid);
    end
    @(negedge clk);
    vectors++;
    if (frame_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_3 frame_valid=%b required 1 three cycles after edge", frame_valid);
    end
    #1;
    golden = 59'h2AAAAAAAAAAAAAA;
    vectors++;
    if (dcf_bits !== golden || bit_count !== 6'd0 || synced !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_result bits=%h cnt=%0d sy=%b required %h 0 1", dcf_bits, bit_count, synced, golden);
    end
  endtask

  task automatic test_bad_pulse();
    int fe0;
    fe0 = fe_cnt;
    hold(1'b1, 300);
    dcf_in = 1'b0;
    settle();
    vectors++;
    if (fe_cnt !== fe0 + 1 || synced !== 1'b0 || bit_count !== 6'd0 || dcf_bits !== golden) begin
      miscompares++;
      $display("FAIL long_pulse errs=%0d sy=%b cnt=%0d bits=%h required %0d 0 0 %h",
               fe_cnt - fe0, synced, bit_count, dcf_bits, 1, golden);
    end
    fe0 = fe_cnt;
    hold(1'b0, 1600);
    hold(1'b1, 20);
    dcf_in = 1'b0;
    settle();
    vectors++;
    if (fe_cnt !== fe0 + 1 || synced !== 1'b0) begin
      miscompares++;
      $display("FAIL short_pulse errs=%0d sy=%b required 1 0", fe_cnt - fe0, synced);
    end
  endtask

  task automatic test_missing_pulse();
    int fe0;
    int fv0;
    hold(1'b0, 1600);
    for (int n = 0; n < 5; n++) send_bit(n[0]);
    vectors++;
    if (bit_count !== 6'd5 || synced !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_gap cnt=%0d sy=%b required 5 1", bit_count, synced);
    end
    fe0 = fe_cnt;
    fv0 = fv_cnt;
    hold(1'b0, 1095);
    dcf_in = 1'b1;
    settle();
    vectors++;
    if (fe_cnt !== fe0 + 1 || fv_cnt !== fv0 || bit_count !== 6'd0 || synced !== 1'b1 || dcf_bits !== golden) begin
      miscompares++;
      $display("FAIL missing_pulse errs=%0d fv=%0d cnt=%0d sy=%b bits=%h required 1 0 0 1 %h",
               fe_cnt - fe0, fv_cnt - fv0, bit_count, synced, dcf_bits, golden);
    end
  endtask

  task automatic test_glitch();
    int fe0;
    hold(1'b1, 46);
    hold(1'b0, 300);
    vectors++;
    if (bit_count !== 6'd1) begin
      miscompares++;
      $display("FAIL glitch_pre cnt=%0d required 1", bit_count);
    end
    fe0 = fe_cnt;
    hold(1'b1, 5);
    dcf_in = 1'b0;
    settle();
    vectors++;
    if (fe_cnt !== fe0 + 1 || synced !== 1'b0 || bit_count !== 6'd0 || dcf_bits !== golden) begin
      miscompares++;
      $display("FAIL glitch errs=%0d sy=%b cnt=%0d bits=%h required 1 0 0 %h",
               fe_cnt - fe0, synced, bit_count, dcf_bits, golden);
    end
  endtask

  task automatic test_loss_while_synced();
    hold(1'b0, 1600);
    hold(1'b1, 50);
    hold(1'b0, 10);
    vectors++;
    if (synced !== 1'b1) begin
      miscompares++;
      $display("FAIL resync synced=%b required 1", synced);
    end
    hold(1'b0, 3000);
    vectors++;
    if (signal_lost !== 1'b1 || synced !== 1'b0 || bit_count !== 6'd0) begin
      miscompares++;
      $display("FAIL loss_synced sl=%b sy=%b cnt=%0d required 1 0 0", signal_lost, synced, bit_count);
    end
    dcf_in = 1'b1;
    settle();
    vectors++;
    if (signal_lost !== 1'b0) begin
      miscompares++;
      $display("FAIL loss_synced_clear sl=%b required 0", signal_lost);
    end
  endtask

  initial begin
    test_reset();
    test_signal_loss_from_reset();
    test_reset_mid_frame();
    test_full_frame();
    test_bad_pulse();
    test_missing_pulse();
    test_glitch();
    test_loss_while_synced();
    vectors++;
    if (fv_cnt !== 1 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL frame_total got %0d frames, %0d pending, required 1 and 0", fv_cnt, exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcf77_bit_decoder.md
DCF77_BIT_DECODER -- requirements
Module: dcf77_bit_decoder

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 16000000, system clock in Hz; sets the 1 ms tick divider (CLOCK_FREQUENCY/1000 cycles per tick).
REQ-002 SHALL have port clk  input  1  system clock; one clock domain; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port dcf_in  input  1  demodulated receiver output, asynchronous to clk; 1 = carrier-reduction pulse.
REQ-005 SHALL have port dcf_bits  output  59  last complete frame; bit n of the minute at index n.
REQ-006 SHALL have port frame_valid  output  1  one-cycle strobe; dcf_bits updated this cycle.
REQ-007 SHALL have port bit_count  output  6  bits received in the current minute, 0..59.
REQ-008 SHALL have port synced  output  1  level; a minute marker has been seen since the last error or loss.
REQ-009 SHALL have port frame_error  output  1  one-cycle strobe; a pulse/gap/count violation occurred.
REQ-010 SHALL have port signal_lost  output  1  level; no dcf_in edge for 3000 ms.

Function
REQ-011 SHALL pass dcf_in through a 2-FF synchronizer; all edge detection uses the second stage.
REQ-012 SHALL generate a 1-cycle tick every CLOCK_FREQUENCY/1000 clk cycles from a free-running prescaler.
REQ-013 SHALL keep a 12-bit ms counter that clears on every synchronized edge, increments on tick, and saturates at 4095.
REQ-014 SHALL use FSM states UNSYNC, GAP (dcf low) and PULSE (dcf high); reset state is UNSYNC.
REQ-015 UNSYNC: rising edge with ms counter >= 1500 -> PULSE, synced=1, bit_count=0; other rising edges stay in UNSYNC.
REQ-016 PULSE: on falling edge, width 40..140 ms SHALL shift in 0, width 141..260 ms SHALL shift in 1, and the state SHALL go to GAP.
REQ-017 Bit shift: new bit enters shift register MSB [58] and contents shift right, so after 59 bits minute bit 0 sits at [0].
REQ-018 PULSE: a width <40 ms or >260 ms SHALL raise frame_error and go to UNSYNC.
REQ-019 GAP: rising edge with gap 700..1000 ms SHALL count a normal second -> PULSE; if bit_count is already 59 -> frame_error, UNSYNC.
REQ-020 GAP: rising edge with gap 1500..2000 ms is the minute marker; if bit_count == 59, copy the shift register to dcf_bits and pulse frame_valid in the same cycle.
REQ-021 Minute marker with bit_count != 59 SHALL pulse frame_error and leave dcf_bits unchanged; either way bit_count=0 -> PULSE, synced stays 1.
REQ-022 GAP: rising edge with any other gap duration SHALL pulse frame_error and go to UNSYNC.
REQ-023 bit_count SHALL increment on each accepted bit and never exceed 59.
REQ-024 ms counter reaching 3000 in any state SHALL set signal_lost=1 and force UNSYNC; the next edge clears signal_lost.
REQ-025 Entering UNSYNC SHALL clear synced and bit_count; dcf_bits SHALL hold the last valid frame.
REQ-026 frame_valid and frame_error SHALL never be asserted in the same cycle and SHALL last exactly one cycle.
REQ-027 Latency: frame_valid SHALL rise 3 clk cycles after the dcf_in rising edge that ends the marker gap (2 sync stages + 1 register).

Reset
REQ-028 While reset=0: state UNSYNC; dcf_bits=0, frame_valid=0, bit_count=0, synced=0, frame_error=0, signal_lost=0; prescaler, ms counter and synchronizer cleared.
REQ-029 Assertion mid-frame SHALL discard partial bits; after release, the block SHALL require a fresh minute marker before synced=1.

Verification (CLOCK_FREQUENCY=16000, 16 cycles/ms)
REQ-030 Stimulus: 1800 ms low, then 59 pulses at 1000 ms spacing, bit n width 200 ms when n odd else 100 ms, then 1900 ms gap and a rising edge -> Response: frame_valid once, dcf_bits=59'h2AAAAAAAAAAAAAA, bit_count 59 -> 0.
REQ-031 Stimulus: same frame with pulse 30 omitted (2000 ms gap mid-frame) -> Response: frame_error at that edge, bit_count=0, no frame_valid, dcf_bits unchanged.
REQ-032 Stimulus: after sync, a 300 ms pulse -> Response: frame_error, synced=0, state UNSYNC.
REQ-033 Stimulus: dcf_in held low 3000 ms -> Response: signal_lost=1, synced=0; the next rising edge clears signal_lost.
REQ-034 Stimulus: reset pulled low at bit 40, then released, then a complete frame -> Response: outputs at reset values, only the post-marker frame is reported.
REQ-035 Stimulus: 5 ms glitch on dcf_in during GAP -> Response: frame_error and UNSYNC; no bit is shifted.
